regfile_dump: RTL and testbench

Debug reader for the CPU register file. On a start pulse it walks a programmable address range through one register-file read port, captures each value, and streams `{address, data}` beats out on a valid/ready interface toward the display/trace logic. The block sits beside the register file and only reads from it. It never writes, so CPU operation is unaffected apart from sharing the read port's address mux.

---
 rtl/regfile_dump_pkg.sv | 11 +
 rtl/regfile_dump_out.sv | 61 ++++++
 rtl/regfile_dump.sv | 104 ++++++++++
 tb/tb_regfile_dump.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump reader.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_out.sv
// Output beat register slice: loads a captured {addr, data, last} beat and
// holds it stable until the consumer accepts it.
module regfile_dump_out #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     clear,
    input  logic [ADDRESS_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     last_in,
    output logic                     out_valid,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last
);

    logic                     valid_d, valid_q;
    logic [ADDRESS_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0]    data_d, data_q;
    logic                     last_d, last_q;

    always_comb begin
        // NOTE: every combinational output gets a hold default first so no latch is inferred.
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = addr_in;
            data_d  = data_in;
            last_d  = last_in;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug reader: walks an address range through one register-file read port
// and streams {address, data} beats on a valid/ready interface.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    output logic [ADDRESS_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    state_t                   state_d, state_q;
    logic [ADDRESS_WIDTH-1:0] rf_addr_d, rf_addr_q;
    logic [ADDRESS_WIDTH-1:0] last_d, last_q;
    logic                     busy_d, busy_q;
    logic                     done_d, done_q;
    logic                     handshake;
    logic                     load_beat;

    assign handshake = (state_q == SEND) && out_valid && out_ready;
    assign load_beat = (state_q == CAPTURE);

    always_comb begin
        state_d   = state_q;
        rf_addr_d = rf_addr_q;
        last_d    = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rf_addr_d = first_addr;
                    last_d    = last_addr;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: state_d = SEND;
            SEND: begin
                if (handshake) begin
                    if (out_last) begin
                        state_d = DONE;
                    end else begin
                        // Natural wrap of the counter gives modulo ranges such as 30..1.
                        rf_addr_d = rf_addr_q + ADDRESS_WIDTH'(1);
                        state_d   = CAPTURE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rf_addr_q <= '0;
            last_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_addr_q <= rf_addr_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    regfile_dump_out #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_beat),
        .clear     (handshake),
        .addr_in   (rf_addr_q),
        .data_in   (rf_data),
        .last_in   (rf_addr_q == last_q),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign rf_addr = rf_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a register-file model feeds the read port,
// expected beats are queued at start and popped as the DUT presents them.
module tb_regfile_dump;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NREG];
    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;

    regfile_dump #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // x0 is hardwired to zero in the register-file model.
    assign rf_data = (rf_addr == '0) ? '0 : regs[rf_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        return (a == '0) ? '0 : regs[a];
    endfunction

    task automatic start_scan(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        a = f;
        forever begin
            exp_q.push_back('{addr: a, data: model_data(a), last: (a == l)});
            if (a == l) break;
            a = a + AW'(1);
        end
        @(negedge clk);
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy, 1);
        check("valid_in_capture", out_valid, 0);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic consume_beat(input int stall, input bit intrude);
        bit    ok;
        beat_t b;
        wait_valid(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
            return;
        end
        b = exp_q.pop_front();
        check("beat_addr", out_addr, b.addr);
        check("beat_data", out_data, b.data);
        check("beat_last", out_last, b.last);
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                if (intrude && s == 0) begin
                    start = 1'b1;
                    first_addr = 5'd3;
                    last_addr = 5'd4;
                end
                @(negedge clk);
                start = 1'b0;
            end
            check("stall_valid", out_valid, 1);
            check("stall_addr", out_addr, b.addr);
            check("stall_data", out_data, b.data);
            check("stall_last", out_last, b.last);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_cleared", out_valid, 0);
        if (stall > 0) out_ready = 1'b0;
    endtask

    task automatic finish_scan(input int n, input int stall, input bit intrude);
        for (int i = 0; i < n; i++) consume_beat(stall, intrude && i == 0);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("queue_drained", exp_q.size(), 0);
        if (stall == 0) check("scan_cycles", cyc - start_cyc + 1, 2 * n + 1);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("busy_cleared", busy, 0);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + i;

        // Reset state and idle hold.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end

        // Full scan, consumer always ready.
        out_ready = 1'b1;
        start_scan(5'd0, 5'd31);
        finish_scan(32, 0, 1'b0);

        // Backpressure with a 5-cycle stall per beat.
        regs[11] = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        start_scan(5'd10, 5'd12);
        finish_scan(3, 5, 1'b0);

        // Wrapping range and single-beat range.
        out_ready = 1'b1;
        start_scan(5'd30, 5'd1);
        finish_scan(4, 0, 1'b0);
        start_scan(5'd5, 5'd5);
        finish_scan(1, 0, 1'b0);

        // Start pulse during SEND must be ignored.
        out_ready = 1'b0;
        start_scan(5'd20, 5'd22);
        finish_scan(3, 2, 1'b1);

        // Reset while beat 3 of a full scan is pending.
        start_scan(5'd0, 5'd31);
        for (int i = 0; i < 3; i++) consume_beat(1, 1'b0);
        wait_valid(ok);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_rf_addr", rf_addr, 0);
        check("abort_addr", out_addr, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_abort_idle", busy, 0);
        start_scan(5'd7, 5'd9);
        finish_scan(3, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
